alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares the single 16-bit CPU ALU between two requesters: requester 0 is the core execute stage, requester 1 is a secondary engine such as a debug or DMA unit.
- Arbitration is round-robin with valid/ready handshakes.
- A lock input gives a requester back-to-back ownership for multi-word carry chains.
- Because the ALU's flag register updates on every clock, the block preserves each requester's carry as context. It uses restore/hold cycles that exploit shlc (carry_out = s_2[15]).

Parameters:
- DATA_W, 16, operand/result width; must equal ALU width.
- RESTORE_EN, 1, 1 = insert carry-restore cycle on owner switch; 0 = switch immediately with no carry context.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&ready.
- req0_op / req1_op  in  3  ALU op field.
- req0_alu_op / req1_alu_op  in  4  ALU alu_op field.
- req0_a, req0_b / req1_a, req1_b  in  DATA_W  operands, driven to s_1 and s_2.
- req0_lock / req1_lock  in  1  keep ownership after this transaction.
- resp0_valid / resp1_valid  out  1  response for that requester.
- resp_result  out  DATA_W  registered result.
- resp_flags  out  4  {O,S,Z,C} of the responded op.
- alu_op_o  out  3  to ALU op.
- alu_alu_op_o  out  4  to ALU alu_op.
- alu_s1_o, alu_s2_o  out  DATA_W  to ALU s_1, s_2.
- alu_result_i  in  DATA_W  ALU combinational result.
- alu_flags_i  in  4  ALU registered flags.

Behaviour:
- State:
  - owner (1b): requester whose carry is currently in alu_flags_i[0].
  - rr (1b): favoured requester.
  - lock_act, lock_id: lock is active and which requester holds it.
  - saved_c[1:0]: saved carry per requester.
  - resp_valid regs, resp_result reg.
- Reset (async, rst_n low) clears all of the above to 0, so owner=0 and rr=0.
  - req*_ready and resp*_valid are forced 0 while rst_n is low.
  - resp_result resets to 0.
  - A response in flight at reset is dropped.
- Candidate selection (combinational):
  - If lock_act, the candidate is lock_id, and only when its valid is high. The other requester is starved.
  - Otherwise the candidate is rr if valid[rr], else !rr if valid[!rr], else none.
- ISSUE: candidate exists and (candidate==owner or RESTORE_EN==0).
  - ready[candidate]=1 and the other ready=0.
  - ALU ports are driven from the candidate's request.
  - On the edge: rr<=!candidate, owner<=candidate.
  - On the edge: lock_act<=lock[candidate], and lock_id<=candidate when lock_act is set.
  - On the edge: resp_valid[candidate]<=1 and resp_result<=alu_result_i.
- RESTORE: candidate exists, candidate!=owner, RESTORE_EN==1.
  - Both readys are 0. This costs exactly one cycle.
  - Drive op=000, alu_op=1111 (shlc), s_1=0, s_2={saved_c[candidate],15'b0}.
  - On the edge: saved_c[owner]<=alu_flags_i[0], owner<=candidate.
  - The next cycle is ISSUE for the candidate, unless lock_act changed, which cannot happen during restore.
- HOLD: no candidate.
  - Drive shlc with s_2={alu_flags_i[0],15'b0} so the owner's carry survives idle cycles.
  - O/S/Z are not preserved; only C is context.
- With RESTORE_EN==0, an owner switch only updates owner; saved_c is unused.
- Response timing:
  - resp*_valid is high for exactly one cycle, the cycle after acceptance.
  - resp_flags = alu_flags_i combinationally in that cycle; these are the flags latched at the issue edge.
  - There is no response backpressure. Throughput is one op per cycle per uncontended requester.
- Simultaneous valid with no lock: rr decides, and alternation is strict under continuous contention, plus restore cycles.
- Lock acquired while the other requester is waiting: the other waits until a locked-requester transaction with lock=0 is accepted.
- Lock holder dropping valid while locked: HOLD is driven, and the lock stays active.

Decomposition:
- Shared package (existing cpu package):
  - OP_ALU=3'b000
  - ALU_SHLC=4'b1111, ALU_ADDC=4'b0010
  - Flag indices FLAG_C=0, FLAG_Z=1, FLAG_S=2, FLAG_O=3
- One sub-module, alu_arb_pick: pure combinational candidate select from valid[1:0], rr, lock_act, lock_id.

Test Plan:
- Single requester: req0 add 0x0003+0x0004 accepted at cycle N -> resp0_valid at N+1, result 0x0007, flags 4'b0000; req1_ready stays 0.
- Contention: both valid for 4 cycles after reset (owner=0) -> grants 0, restore, 1, restore, 0… Each restore cycle has both readys 0.
- Carry context:
  - req0 add 0xFFFF+0x0001 gives C=1.
  - Then req1 add 1+1 gives C=0.
  - Then req0 addc 0+0 -> result 0x0001 (carry restored via shlc).
- Lock chain:
  - req0 add 0xFFFF+1 with lock=1, req1 valid throughout.
  - Then req0 addc 0+0 with lock=0 -> the addc result is 0x0001; req1 is granted only after the addc is accepted.
- Idle hold: C=1 from req0, then 5 idle cycles, then req0 addc 0+0 -> result 0x0001.
- Reset mid-op: rst_n low in the cycle after acceptance -> resp0_valid 0 immediately; post-reset owner=0, rr=0, saved_c=0.

Source files
------------

// File: rtl/alu_share_arbiter_pkg.sv
// Shared CPU constants used by the ALU share arbiter.
// ALU opcodes, flag bit positions and arbiter cycle kinds.
package alu_share_arbiter_pkg;

    localparam logic [2:0] OP_ALU   = 3'b000;
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_ADDC = 4'b0010;
    localparam logic [3:0] ALU_SHLC = 4'b1111;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_S = 2;
    localparam int FLAG_O = 3;

    // Kind of cycle the shared ALU is running this clock.
    typedef enum logic [1:0] {
        M_HOLD    = 2'd0,
        M_ISSUE   = 2'd1,
        M_RESTORE = 2'd2
    } arb_mode_e;

endpackage

// File: rtl/alu_arb_pick.sv
// Candidate select for the ALU share arbiter.
// A held lock overrides round-robin and starves the other side.
module alu_arb_pick (
    input  logic [1:0] valid_i,
    input  logic       rr_i,
    input  logic       lock_act_i,
    input  logic       lock_id_i,
    output logic       cand_vld_o,
    output logic       cand_o
);

    // Lock holder first, else favoured side, else the other side.
    always_comb begin
        cand_vld_o = 1'b0;
        cand_o     = rr_i;
        if (lock_act_i) begin
            cand_o     = lock_id_i;
            cand_vld_o = valid_i[lock_id_i];
        end else if (valid_i[rr_i]) begin
            cand_o     = rr_i;
            cand_vld_o = 1'b1;
        end else if (valid_i[~rr_i]) begin
            cand_o     = ~rr_i;
            cand_vld_o = 1'b1;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two requesters, keeping each side's carry
// as context by shlc restore cycles on owner switch and idle hold.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter bit RESTORE_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic              req1_valid,
    output logic              req0_ready,
    output logic              req1_ready,
    input  logic [2:0]        req0_op,
    input  logic [2:0]        req1_op,
    input  logic [3:0]        req0_alu_op,
    input  logic [3:0]        req1_alu_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic              req0_lock,
    input  logic              req1_lock,
    output logic              resp0_valid,
    output logic              resp1_valid,
    output logic [DATA_W-1:0] resp_result,
    output logic [3:0]        resp_flags,
    output logic [2:0]        alu_op_o,
    output logic [3:0]        alu_alu_op_o,
    output logic [DATA_W-1:0] alu_s1_o,
    output logic [DATA_W-1:0] alu_s2_o,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic [3:0]        alu_flags_i
);

    localparam logic [DATA_W-2:0] LOW0 = '0;

    logic              owner_q, owner_d;
    logic              rr_q, rr_d;
    logic              lock_act_q, lock_act_d;
    logic              lock_id_q, lock_id_d;
    logic [1:0]        saved_c_q, saved_c_d;
    logic [1:0]        resp_vld_q, resp_vld_d;
    logic [DATA_W-1:0] resp_result_q, resp_result_d;

    logic              cand_vld;
    logic              cand;
    arb_mode_e         mode;
    logic [1:0]        rdy;

    logic [2:0]        sel_op;
    logic [3:0]        sel_alu_op;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic              sel_lock;

    alu_arb_pick u_pick (
        .valid_i    ({req1_valid, req0_valid}),
        .rr_i       (rr_q),
        .lock_act_i (lock_act_q),
        .lock_id_i  (lock_id_q),
        .cand_vld_o (cand_vld),
        .cand_o     (cand)
    );

    // Mux the candidate's request fields.
    always_comb begin
        sel_op     = cand ? req1_op     : req0_op;
        sel_alu_op = cand ? req1_alu_op : req0_alu_op;
        sel_a      = cand ? req1_a      : req0_a;
        sel_b      = cand ? req1_b      : req0_b;
        sel_lock   = cand ? req1_lock   : req0_lock;
    end

    // Classify the cycle: issue, carry restore, or idle hold.
    always_comb begin
        mode = M_HOLD;
        if (cand_vld) begin
            if (cand == owner_q || !RESTORE_EN) begin
                mode = M_ISSUE;
            end else begin
                mode = M_RESTORE;
            end
        end
    end

    // Drive the ALU, the readys and the next state for each cycle kind.
    always_comb begin
        owner_d       = owner_q;
        rr_d          = rr_q;
        lock_act_d    = lock_act_q;
        lock_id_d     = lock_id_q;
        saved_c_d     = saved_c_q;
        resp_vld_d    = 2'b00;
        resp_result_d = resp_result_q;
        rdy           = 2'b00;
        alu_op_o      = OP_ALU;
        alu_alu_op_o  = ALU_SHLC;
        alu_s1_o      = '0;
        alu_s2_o      = {alu_flags_i[FLAG_C], LOW0};
        unique case (mode)
            M_ISSUE: begin
                rdy[cand]        = 1'b1;
                alu_op_o         = sel_op;
                alu_alu_op_o     = sel_alu_op;
                alu_s1_o         = sel_a;
                alu_s2_o         = sel_b;
                owner_d          = cand;
                rr_d             = ~cand;
                lock_act_d       = sel_lock;
                if (sel_lock) begin
                    lock_id_d = cand;
                end
                resp_vld_d[cand] = 1'b1;
                resp_result_d    = alu_result_i;
            end
            M_RESTORE: begin
                alu_s2_o           = {saved_c_q[cand], LOW0};
                saved_c_d[owner_q] = alu_flags_i[FLAG_C];
                owner_d            = cand;
            end
            default: begin
            end
        endcase
    end

    // Arbiter state and the registered response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q       <= 1'b0;
            rr_q          <= 1'b0;
            lock_act_q    <= 1'b0;
            lock_id_q     <= 1'b0;
            saved_c_q     <= 2'b00;
            resp_vld_q    <= 2'b00;
            resp_result_q <= '0;
        end else begin
            owner_q       <= owner_d;
            rr_q          <= rr_d;
            lock_act_q    <= lock_act_d;
            lock_id_q     <= lock_id_d;
            saved_c_q     <= saved_c_d;
            resp_vld_q    <= resp_vld_d;
            resp_result_q <= resp_result_d;
        end
    end

    assign req0_ready  = rst_n & rdy[0];
    assign req1_ready  = rst_n & rdy[1];
    assign resp0_valid = resp_vld_q[0];
    assign resp1_valid = resp_vld_q[1];
    assign resp_result = resp_result_q;
    assign resp_flags  = alu_flags_i;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter with a small ALU model and a
// scoreboard of expected responses popped by a monitor.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [2:0]  req0_op = '0, req1_op = '0;
    logic [3:0]  req0_alu_op = '0, req1_alu_op = '0;
    logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        req0_lock = 1'b0, req1_lock = 1'b0;
    logic        resp0_valid, resp1_valid;
    logic [15:0] resp_result;
    logic [3:0]  resp_flags;
    logic [2:0]  alu_op;
    logic [3:0]  alu_alu_op;
    logic [15:0] alu_s1, alu_s2, alu_res;
    logic [3:0]  alu_flags;

    alu_share_arbiter #(.DATA_W(16), .RESTORE_EN(1'b1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid   (req0_valid),
        .req1_valid   (req1_valid),
        .req0_ready   (req0_ready),
        .req1_ready   (req1_ready),
        .req0_op      (req0_op),
        .req1_op      (req1_op),
        .req0_alu_op  (req0_alu_op),
        .req1_alu_op  (req1_alu_op),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .req0_lock    (req0_lock),
        .req1_lock    (req1_lock),
        .resp0_valid  (resp0_valid),
        .resp1_valid  (resp1_valid),
        .resp_result  (resp_result),
        .resp_flags   (resp_flags),
        .alu_op_o     (alu_op),
        .alu_alu_op_o (alu_alu_op),
        .alu_s1_o     (alu_s1),
        .alu_s2_o     (alu_s2),
        .alu_result_i (alu_res),
        .alu_flags_i  (alu_flags)
    );

    always #5 clk = ~clk;

    // Minimal ALU: add, addc, shlc; flags {O,S,Z,C} registered each clock.
    logic [16:0] sum;
    logic [3:0]  nflags;
    logic        ovf, cout;
    always_comb begin
        sum  = '0;
        ovf  = 1'b0;
        cout = 1'b0;
        if (alu_op == 3'b000) begin
            case (alu_alu_op)
                4'b0000: sum = {1'b0, alu_s1} + {1'b0, alu_s2};
                4'b0010: sum = {1'b0, alu_s1} + {1'b0, alu_s2}
                             + {16'd0, alu_flags[0]};
                4'b1111: sum = {alu_s2, alu_flags[0]};
                default: sum = '0;
            endcase
        end
        alu_res = sum[15:0];
        cout    = sum[16];
        if (alu_alu_op == 4'b0000 || alu_alu_op == 4'b0010)
            ovf = (alu_s1[15] == alu_s2[15]) && (alu_res[15] != alu_s1[15]);
        nflags = {ovf, alu_res[15], alu_res == 16'd0, cout};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) alu_flags <= 4'b0000;
        else        alu_flags <= nflags;
    end

    typedef struct {
        int          id;
        logic [15:0] res;
        logic [3:0]  flg;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          trace[$];
    bit          trace_on = 1'b0;
    bit          saw_r1 = 1'b0;
    logic [15:0] e_res[2];
    logic [3:0]  e_flg[2];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Acceptance: push the expected response when a handshake completes.
    always @(negedge clk) begin
        if (req0_valid && req0_ready)
            sb.push_back('{0, e_res[0], e_flg[0], cyc});
        if (req1_valid && req1_ready)
            sb.push_back('{1, e_res[1], e_flg[1], cyc});
        if (req1_ready) saw_r1 = 1'b1;
        if (trace_on)
            trace.push_back(req0_ready ? 0 : (req1_ready ? 1 : 2));
    end

    // Monitor: pop and compare whenever a response is presented.
    always @(negedge clk) begin
        exp_t e;
        if (resp0_valid || resp1_valid) begin
            chk("resp_onehot", {resp1_valid, resp0_valid} == 2'b11, 0);
            if (sb.size() == 0) begin
                chk("resp_unexpected", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("resp_id", resp1_valid ? 1 : 0, e.id);
                chk("resp_result", resp_result, e.res);
                chk("resp_flags", resp_flags, e.flg);
                chk("resp_latency", cyc, e.cyc + 1);
            end
        end
    end

    task automatic drive(input int id, input logic [3:0] aop,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic lk, input logic [15:0] er,
                         input logic [3:0] ef);
        bit acc = 1'b0;
        int n = 0;
        e_res[id] = er;
        e_flg[id] = ef;
        if (id == 0) begin
            req0_op = 3'b000; req0_alu_op = aop;
            req0_a = a; req0_b = b; req0_lock = lk; req0_valid = 1'b1;
        end else begin
            req1_op = 3'b000; req1_alu_op = aop;
            req1_a = a; req1_b = b; req1_lock = lk; req1_valid = 1'b1;
        end
        while (!acc) begin
            @(negedge clk);
            acc = (id == 0) ? req0_ready : req1_ready;
            @(posedge clk);
            #1;
            n++;
            if (!acc && n > 40) begin
                chk("accept_timeout", id, 99);
                break;
            end
        end
        if (id == 0) begin req0_valid = 1'b0; req0_lock = 1'b0; end
        else begin req1_valid = 1'b0; req1_lock = 1'b0; end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin
        int exp_c[7];
        exp_c = '{0, 2, 1, 2, 0, 2, 1};

        rst_n = 1'b0;
        #3;
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        chk("rst_resp0", resp0_valid, 0);
        chk("rst_result", resp_result, 0);
        do_reset();

        // Single requester: 3+4, req1 never readied.
        saw_r1 = 1'b0;
        drive(0, 4'b0000, 16'h0003, 16'h0004, 1'b0, 16'h0007, 4'b0000);
        drain();
        chk("single_r1_never_ready", saw_r1, 0);

        // Contention from reset: 0, restore, 1, restore, 0, restore, 1.
        do_reset();
        trace.delete();
        trace_on = 1'b1;
        fork
            begin
                drive(0, 4'b0000, 16'h0001, 16'h0002, 1'b0, 16'h0003, 4'b0000);
                drive(0, 4'b0000, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 4'b0011);
            end
            begin
                drive(1, 4'b0000, 16'h0005, 16'h0006, 1'b0, 16'h000B, 4'b0000);
                drive(1, 4'b0010, 16'h0000, 16'h0000, 1'b0, 16'h0000, 4'b0010);
            end
        join
        trace_on = 1'b0;
        drain();
        chk("trace_len", trace.size() >= 7, 1);
        for (int i = 0; i < 7; i++)
            if (i < trace.size()) chk($sformatf("grant_c%0d", i), trace[i], exp_c[i]);

        // Carry context across an owner switch.
        do_reset();
        drive(0, 4'b0000, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 4'b0011);
        drive(1, 4'b0000, 16'h0001, 16'h0001, 1'b0, 16'h0002, 4'b0000);
        drive(0, 4'b0010, 16'h0000, 16'h0000, 1'b0, 16'h0001, 4'b0000);
        drive(0, 4'b0000, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 4'b1100);
        drain();

        // Lock chain: req1 waits until the unlocking addc is accepted.
        do_reset();
        trace.delete();
        trace_on = 1'b1;
        fork
            begin
                drive(0, 4'b0000, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 4'b0011);
                drive(0, 4'b0010, 16'h0000, 16'h0000, 1'b0, 16'h0001, 4'b0000);
            end
            drive(1, 4'b0000, 16'h0001, 16'h0001, 1'b0, 16'h0002, 4'b0000);
        join
        trace_on = 1'b0;
        drain();
        chk("lock_len", trace.size() >= 4, 1);
        if (trace.size() >= 4) begin
            chk("lock_g0", trace[0], 0);
            chk("lock_g1", trace[1], 0);
            chk("lock_g2", trace[2], 2);
            chk("lock_g3", trace[3], 1);
        end

        // Idle hold keeps the owner's carry.
        do_reset();
        drive(0, 4'b0000, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 4'b0011);
        repeat (5) @(posedge clk);
        #1;
        drive(0, 4'b0010, 16'h0000, 16'h0000, 1'b0, 16'h0001, 4'b0000);
        drain();

        // Reset mid-op drops the response and clears carry context.
        do_reset();
        drive(1, 4'b0000, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 4'b0011);
        drive(0, 4'b0000, 16'h0003, 16'h0004, 1'b0, 16'h0007, 4'b0000);
        rst_n = 1'b0;
        #1;
        chk("midrst_resp0", resp0_valid, 0);
        chk("midrst_ready0", req0_ready, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        trace.delete();
        trace_on = 1'b1;
        drive(1, 4'b0010, 16'h0000, 16'h0000, 1'b0, 16'h0000, 4'b0010);
        trace_on = 1'b0;
        drain();
        chk("post_rst_len", trace.size(), 2);
        if (trace.size() == 2) begin
            chk("post_rst_restore", trace[0], 2);
            chk("post_rst_grant", trace[1], 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
